// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// flag bit positions inside {N,Z,C,V}, and the predication FSM states.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_IT_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition-code evaluator against a {N,Z,C,V} flag word.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Predicated-execution unit: evaluates each instruction's condition against
// the architectural flags and sequences IT-style predicated blocks.
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int PIPE   = 0,
    parameter int IT_MAX = 4,
    parameter int LW     = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [3:0]        cond_i,
    input  logic [1:0]        flag_w_i,
    input  logic [3:0]        alu_flags_i,
    input  logic              it_start_i,
    input  logic [3:0]        it_cond_i,
    input  logic [IT_MAX-1:0] it_mask_i,
    input  logic [LW-1:0]     it_len_i,
    output logic              cond_ex_o,
    output logic              valid_o,
    output logic [3:0]        flags_o,
    output logic              it_active_o,
    output logic              err_o
);

    localparam int SW = (IT_MAX > 1) ? $clog2(IT_MAX) : 1;

    state_e            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [LW-1:0]     len_q, len_d;
    logic [IT_MAX-1:0] mask_q, mask_d;
    logic [3:0]        itCond_q, itCond_d;
    logic [3:0]        flags_q, flags_d;
    logic              err_q, err_d;

    logic [3:0] effCond;
    logic       pass;
    logic       execNow;
    logic       lenOk;
    logic       accept;
    logic       slotLast;

    // Else slots invert the base condition; AL/NV bases have no inverse and never execute.
    always_comb begin
        effCond = cond_i;
        if (state_q == ST_IT_ACTIVE) begin
            if (slot_q == '0 || mask_q[slot_q]) begin
                effCond = itCond_q;
            end else if (itCond_q[3:1] == 3'b111) begin
                effCond = COND_NV;
            end else begin
                effCond = {itCond_q[3:1], ~itCond_q[0]};
            end
        end
    end

    cond_eval u_cond_eval (
        .cond_i  (effCond),
        .flags_i (flags_q),
        .pass_o  (pass)
    );

    assign execNow  = valid_i && pass;
    assign lenOk    = (it_len_i != '0) && (it_len_i <= LW'(IT_MAX));
    assign accept   = it_start_i && (state_q == ST_IDLE) && !valid_i && lenOk;
    assign slotLast = (LW'(slot_q) + LW'(1)) == len_q;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        len_d    = len_q;
        mask_d   = mask_q;
        itCond_d = itCond_q;
        flags_d  = flags_q;
        err_d    = it_start_i && !accept;

        if (execNow) begin
            if (flag_w_i[1]) begin
                flags_d[FLAG_N] = alu_flags_i[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
            end
            if (flag_w_i[0]) begin
                flags_d[FLAG_C] = alu_flags_i[FLAG_C];
                flags_d[FLAG_V] = alu_flags_i[FLAG_V];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_IT_ACTIVE;
                    slot_d   = '0;
                    len_d    = it_len_i;
                    mask_d   = it_mask_i;
                    itCond_d = it_cond_i;
                end
            end
            ST_IT_ACTIVE: begin
                if (valid_i) begin
                    if (slotLast) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            len_q    <= '0;
            mask_q   <= '0;
            itCond_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            len_q    <= len_d;
            mask_q   <= mask_d;
            itCond_q <= itCond_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    // The registered variant captures the decision made against pre-update flags.
    generate
        if (PIPE != 0) begin : g_pipe
            logic condEx_q;
            logic valid_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    condEx_q <= 1'b0;
                    valid_q  <= 1'b0;
                end else begin
                    condEx_q <= execNow;
                    valid_q  <= valid_i;
                end
            end

            assign cond_ex_o = condEx_q;
            assign valid_o   = valid_q;
        end else begin : g_comb
            assign cond_ex_o = execNow && reset;
            assign valid_o   = valid_i && reset;
        end
    endgenerate

    assign flags_o     = flags_q;
    assign it_active_o = (state_q == ST_IT_ACTIVE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: a PIPE=0 and a PIPE=1 instance share stimulus and are
// checked every cycle against a queue-based predication model plus directed literals.
module tb_cond_exec_unit;

    localparam int IT_MAX = 4;
    localparam int LW     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              validI;
    logic [3:0]        condI;
    logic [1:0]        flagWI;
    logic [3:0]        aluFlagsI;
    logic              itStartI;
    logic [3:0]        itCondI;
    logic [IT_MAX-1:0] itMaskI;
    logic [LW-1:0]     itLenI;

    logic       ex0, valid0, active0, err0;
    logic [3:0] flags0;
    logic       ex1, valid1, active1, err1;
    logic [3:0] flags1;

    cond_exec_unit #(.PIPE(0), .IT_MAX(IT_MAX), .LW(LW)) dut0 (
        .clk(clk), .reset(reset), .valid_i(validI), .cond_i(condI),
        .flag_w_i(flagWI), .alu_flags_i(aluFlagsI), .it_start_i(itStartI),
        .it_cond_i(itCondI), .it_mask_i(itMaskI), .it_len_i(itLenI),
        .cond_ex_o(ex0), .valid_o(valid0), .flags_o(flags0),
        .it_active_o(active0), .err_o(err0)
    );

    cond_exec_unit #(.PIPE(1), .IT_MAX(IT_MAX), .LW(LW)) dut1 (
        .clk(clk), .reset(reset), .valid_i(validI), .cond_i(condI),
        .flag_w_i(flagWI), .alu_flags_i(aluFlagsI), .it_start_i(itStartI),
        .it_cond_i(itCondI), .it_mask_i(itMaskI), .it_len_i(itLenI),
        .cond_ex_o(ex1), .valid_o(valid1), .flags_o(flags1),
        .it_active_o(active1), .err_o(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return mid-cycle.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [1:0] fw,
                                 input logic [3:0] alu, input logic st, input logic [3:0] itc,
                                 input logic [IT_MAX-1:0] msk, input logic [LW-1:0] len);
        @(posedge clk);
        #1;
        validI    = v;
        condI     = c;
        flagWI    = fw;
        aluFlagsI = alu;
        itStartI  = st;
        itCondI   = itc;
        itMaskI   = msk;
        itLenI    = len;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
    endtask

    function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: an accepted block becomes a queue of per-instruction conditions.
    logic [3:0] mFlags = 4'h0;
    logic [3:0] itQ[$];
    logic       pipeEx = 1'b0;
    logic       pipeValid = 1'b0;
    logic       expErr = 1'b0;

    always @(negedge clk) begin : compare
        logic [3:0] eff;
        logic       expEx;
        logic       wasIdle;
        logic       acc;
        logic       isThen;
        if (!reset) begin
            checkBit("rst ex0", ex0, 1'b0);
            checkBit("rst valid0", valid0, 1'b0);
            checkOutput("rst flags0", flags0, 4'h0);
            checkBit("rst active0", active0, 1'b0);
            checkBit("rst err0", err0, 1'b0);
            checkBit("rst ex1", ex1, 1'b0);
            checkBit("rst valid1", valid1, 1'b0);
            checkOutput("rst flags1", flags1, 4'h0);
            checkBit("rst active1", active1, 1'b0);
            itQ.delete();
            mFlags    = 4'h0;
            pipeEx    = 1'b0;
            pipeValid = 1'b0;
            expErr    = 1'b0;
        end else begin
            wasIdle = (itQ.size() == 0);
            eff     = wasIdle ? condI : itQ[0];
            expEx   = validI && evalCond(eff, mFlags);

            checkBit("model ex0", ex0, expEx);
            checkBit("model valid0", valid0, validI);
            checkOutput("model flags0", flags0, mFlags);
            checkBit("model active0", active0, !wasIdle);
            checkBit("model err0", err0, expErr);
            checkBit("model ex1", ex1, pipeEx);
            checkBit("model valid1", valid1, pipeValid);
            checkOutput("model flags1", flags1, mFlags);
            checkBit("model active1", active1, !wasIdle);
            checkBit("model err1", err1, expErr);

            pipeEx    = expEx;
            pipeValid = validI;
            if (expEx) begin
                if (flagWI[1]) mFlags[3:2] = aluFlagsI[3:2];
                if (flagWI[0]) mFlags[1:0] = aluFlagsI[1:0];
            end
            if (!wasIdle && validI) void'(itQ.pop_front());

            acc = itStartI && wasIdle && !validI && itLenI >= 1 && itLenI <= IT_MAX;
            if (acc) begin
                for (int i = 0; i < int'(itLenI); i++) begin
                    isThen = (i == 0) || itMaskI[i];
                    if (isThen)                   itQ.push_back(itCondI);
                    else if (itCondI[3:1] == 3'b111) itQ.push_back(4'hF);
                    else                          itQ.push_back({itCondI[3:1], ~itCondI[0]});
                end
            end
            expErr = itStartI && !acc;
        end
    end

    initial begin
        reset     = 1'b0;
        validI    = 1'b0;
        condI     = 4'h0;
        flagWI    = 2'b00;
        aluFlagsI = 4'h0;
        itStartI  = 1'b0;
        itCondI   = 4'h0;
        itMaskI   = '0;
        itLenI    = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset flags", flags0, 4'h0);
        checkBit("reset it_active", active0, 1'b0);
        checkBit("reset err", err0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Exhaustive table: load each flag value, then try every condition.
        for (int f = 0; f < 16; f++) begin
            applyStimulus(1'b1, 4'hE, 2'b11, 4'(f), 1'b0, 4'h0, '0, '0);
            for (int c = 0; c < 16; c++)
                applyStimulus(1'b1, 4'(c), 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        end

        // Partial flag write; the updated flags are seen by the next instruction only.
        applyStimulus(1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 4'h0, '0, '0);
        applyStimulus(1'b1, 4'h0, 2'b01, 4'b0011, 1'b0, 4'h0, '0, '0);
        checkBit("eq with Z", ex0, 1'b1);
        checkOutput("flags before write", flags0, 4'b0100);
        applyStimulus(1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkOutput("partial write flags", flags0, 4'b0111);
        checkBit("ne after write", ex0, 1'b0);
        checkBit("pipe valid d1", valid1, 1'b1);
        checkBit("pipe ex d1", ex1, 1'b1);
        idleCycle();
        checkBit("pipe valid d2", valid1, 1'b1);
        checkBit("pipe ex d2", ex1, 1'b0);
        idleCycle();
        checkBit("pipe valid d3", valid1, 1'b0);

        // IT block EQ, then/else/then, with an idle gap; cond_i is ignored inside.
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'h0, 4'b0101, 3'd3);
        checkBit("it start not yet active", active0, 1'b0);
        applyStimulus(1'b1, 4'hF, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("it slot0 active", active0, 1'b1);
        checkBit("it slot0 ex", ex0, 1'b1);
        idleCycle();
        checkBit("it gap active", active0, 1'b1);
        checkBit("it gap ex", ex0, 1'b0);
        applyStimulus(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("it slot1 else ex", ex0, 1'b0);
        applyStimulus(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("it slot2 ex", ex0, 1'b1);
        idleCycle();
        checkBit("it ended", active0, 1'b0);

        // Rejected starts: while active, zero length, over-length, with valid_i.
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'hE, 4'b0000, 3'd2);
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'h0, 4'b1111, 3'd1);
        checkBit("err not early", err0, 1'b0);
        idleCycle();
        checkBit("err while active", err0, 1'b1);
        checkBit("err pipe inst", err1, 1'b1);
        checkBit("still active", active0, 1'b1);
        applyStimulus(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("err single pulse", err0, 1'b0);
        checkBit("al slot0 ex", ex0, 1'b1);
        applyStimulus(1'b1, 4'hE, 2'b11, 4'b1111, 1'b0, 4'h0, '0, '0);
        checkBit("al else slot never", ex0, 1'b0);
        idleCycle();
        checkBit("2-block ended", active0, 1'b0);
        checkOutput("flags kept", flags0, 4'b0111);
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'hE, 4'b1111, 3'd0);
        idleCycle();
        checkBit("err len0", err0, 1'b1);
        checkBit("len0 idle", active0, 1'b0);
        idleCycle();
        checkBit("err len0 clears", err0, 1'b0);
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'hE, 4'b1111, 3'd5);
        idleCycle();
        checkBit("err len5", err0, 1'b1);
        checkBit("len5 idle", active0, 1'b0);
        applyStimulus(1'b1, 4'hE, 2'b00, 4'h0, 1'b1, 4'hE, 4'b1111, 3'd2);
        idleCycle();
        checkBit("err with valid", err0, 1'b1);
        checkBit("valid start idle", active0, 1'b0);
        checkOutput("flags after errors", flags0, 4'b0111);

        // Reset mid-block abandons it; the next instruction uses cond_i again.
        applyStimulus(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 4'hE, 4'b1111, 3'd4);
        applyStimulus(1'b1, 4'h0, 2'b11, 4'b1010, 1'b0, 4'h0, '0, '0);
        applyStimulus(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkOutput("flags in block", flags0, 4'b1010);
        @(posedge clk);
        #1;
        validI = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        checkOutput("mid reset flags", flags0, 4'h0);
        checkBit("mid reset active", active0, 1'b0);
        checkBit("mid reset pipe valid", valid1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("post reset AL", ex0, 1'b1);
        applyStimulus(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0, '0, '0);
        checkBit("post reset EQ", ex0, 1'b0);
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 Parameter PIPE, default 0, meaning output latency select: 0 = combinational decision, 1 = registered decision.
REQ-002 Parameter IT_MAX, default 4, meaning maximum predicated-block length.
REQ-003 Parameter LW, default $clog2(IT_MAX+1), meaning width of the it_len_i port.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 valid_i  in  1  one instruction presented this cycle.
REQ-007 cond_i  in  4  instruction condition field.
REQ-008 flag_w_i  in  2  flag write enables: bit1 = N,Z group; bit0 = C,V group.
REQ-009 alu_flags_i  in  4  new flags {N,Z,C,V}.
REQ-010 it_start_i  in  1  open a predicated block.
REQ-011 it_cond_i  in  4  base condition of the block.
REQ-012 it_mask_i  in  IT_MAX  per-slot then/else selector; 1 = then, 0 = else; bit0 is ignored.
REQ-013 it_len_i  in  LW  number of instructions in the block.
REQ-014 cond_ex_o  out  1  instruction executes.
REQ-015 valid_o  out  1  cond_ex_o is meaningful.
REQ-016 flags_o  out  4  architectural flag register {N,Z,C,V}.
REQ-017 it_active_o  out  1  a predicated block is in progress.
REQ-018 err_o  out  1  single-cycle pulse on a rejected it_start_i.

Function
REQ-019 Condition evaluation uses flags_o and SHALL follow the table: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never 0.
REQ-020 FSM states: IDLE and IT_ACTIVE, with a slot counter `slot` (0..IT_MAX-1) and a stored length, mask and base condition.
REQ-021 In IDLE, the effective condition SHALL be cond_i.
REQ-022 In IT_ACTIVE, cond_i SHALL be ignored; the effective condition SHALL be it_cond if slot==0 or mask[slot]==1, otherwise {it_cond[3:1], ~it_cond[0]}.
REQ-023 In IT_ACTIVE, an else slot with base condition 1110 or 1111 SHALL evaluate as never.
REQ-024 In IDLE, it_start_i=1 with valid_i=0 and 1<=it_len_i<=IT_MAX SHALL latch it_cond_i, it_mask_i and it_len_i, clear slot, and enter IT_ACTIVE on the next edge.
REQ-025 it_start_i SHALL be rejected, with err_o=1 on the next cycle and no state change, if it arrives in IT_ACTIVE, with valid_i=1, with it_len_i==0, or with it_len_i>IT_MAX.
REQ-026 Each valid_i cycle in IT_ACTIVE SHALL consume one slot; the consumption that reaches the stored length SHALL return the FSM to IDLE at that edge.
REQ-027 Cycles with valid_i=0 SHALL NOT advance the slot.
REQ-028 Flags write: at the edge of a valid_i cycle whose cond_ex is 1, flag_w_i[1] SHALL load N,Z and flag_w_i[0] SHALL load C,V from alu_flags_i.
REQ-029 A failed condition SHALL leave the flags unchanged.
REQ-030 Updated flags SHALL be visible to the next instruction, with no bypass within the same cycle.
REQ-031 With PIPE=0, cond_ex_o SHALL equal the evaluated condition in the same cycle and valid_o SHALL equal valid_i.
REQ-032 With PIPE=1, cond_ex_o and valid_o SHALL be registered, appearing one cycle later, and are evaluated against the pre-update flags.
REQ-033 cond_ex_o SHALL be 0 whenever valid_o is 0.
REQ-034 it_active_o SHALL be 1 exactly in IT_ACTIVE.

Reset
REQ-035 reset low SHALL immediately force: flags_o=0000, FSM to IDLE, slot=0, stored mask/len/cond=0, cond_ex_o=0, valid_o=0, it_active_o=0, err_o=0.
REQ-036 Reset asserted mid-block SHALL abandon the block; after release, the first instruction uses cond_i.

Structure
REQ-037 The shared package cond_pkg SHALL hold the 4-bit condition-code enum, the flag bit-index constants N=3, Z=2, C=1, V=0, and the FSM state typedef.
REQ-038 Condition evaluation SHALL be a separate combinational sub-module cond_eval (cond, flags -> pass), instantiated once.

Verification
REQ-039 Reset, then all 16 cond codes x 16 flag values, loaded via flag_w_i=11 -> cond_ex_o matches the REQ-019 table for all 256 cases.
REQ-040 Load flags 0100 (Z=1); instruction cond 0000 with flag_w_i=01 and alu_flags_i 0011 -> cond_ex_o=1, flags_o becomes 0111; next instruction cond 0001 -> cond_ex_o=0.
REQ-041 IT block: it_cond_i=0000, it_mask_i=0101, it_len_i=3 with Z=1, then three valid_i cycles (one idle gap in between) -> cond_ex_o=1,0,1; it_active_o falls after the third.
REQ-042 Error cases: it_start_i while it_active_o=1, it_len_i=0, and it_len_i=5 -> err_o single-cycle pulse in each case, with no slot or flag change.
REQ-043 PIPE=1: same stimulus as REQ-040 -> cond_ex_o/valid_o delayed exactly one cycle with identical values.
REQ-044 Assert reset after slot 1 of a 4-long block -> flags_o=0000, it_active_o=0; a following instruction with cond 1110 -> cond_ex_o=1.
